// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups, GPS groups per stage.
// Latency: STAGES = WIDTH/(4*GPS) cycles from the accepting edge to out_valid; one result per cycle.
// Backpressure: whole pipeline advances as a unit (adv = ~out_valid | out_ready); in_ready = adv.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GPS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NG     = WIDTH / 4;
    localparam int STAGES = NG / GPS;

    typedef struct packed {
        logic [3:0] s;
        logic       c3;
        logic       c4;
    } grp_t;

    function automatic grp_t cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] p;
        logic [3:0] g;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        grp_t       r;
        p  = x ^ y;
        g  = x & y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        r.s  = p ^ {c3, c2, c1, c0};
        r.c3 = c3;
        r.c4 = c4;
        return r;
    endfunction

    logic              adv;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cry_q, cry_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];

    logic              out_vld_q, out_vld_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    grp_t              grp_r [STAGES][GPS];
    logic [GPS:0]      chain [STAGES];
    logic [WIDTH-1:0]  stg_s [STAGES];

    // Stage l reads its level register: operands for its own groups, the registered
    // carry from the stage below, and the sum groups already resolved below it.
    always_comb begin : stage_eval
        for (int l = 0; l < STAGES; l++) begin
            chain[l]    = '0;
            stg_s[l]    = s_q[l];
            chain[l][0] = cry_q[l];
            for (int k = 0; k < GPS; k++) begin
                grp_r[l][k] = cla4(a_q[l][4*(l*GPS+k) +: 4], b_q[l][4*(l*GPS+k) +: 4], chain[l][k]);
                stg_s[l][4*(l*GPS+k) +: 4] = grp_r[l][k].s;
                chain[l][k+1] = grp_r[l][k].c4;
            end
        end
    end

    always_comb begin : next_state
        adv       = ~out_vld_q | out_ready;
        vld_d     = vld_q;
        cry_d     = cry_q;
        for (int l = 0; l < STAGES; l++) begin
            a_d[l] = a_q[l];
            b_d[l] = b_q[l];
            s_d[l] = s_q[l];
        end
        out_vld_d = out_vld_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;

        if (adv) begin
            // Subtraction is a + ~b + 1: b is conditioned once at capture, cin forced high.
            vld_d[0] = in_valid;
            cry_d[0] = sub | cin;
            a_d[0]   = a;
            b_d[0]   = sub ? ~b : b;
            s_d[0]   = '0;
            for (int l = 1; l < STAGES; l++) begin
                vld_d[l] = vld_q[l-1];
                cry_d[l] = chain[l-1][GPS];
                a_d[l]   = a_q[l-1];
                b_d[l]   = b_q[l-1];
                s_d[l]   = stg_s[l-1];
            end
            out_vld_d = vld_q[STAGES-1];
            sum_d     = stg_s[STAGES-1];
            cout_d    = chain[STAGES-1][GPS];
            ovf_d     = grp_r[STAGES-1][GPS-1].c3 ^ chain[STAGES-1][GPS];
            zero_d    = (stg_s[STAGES-1] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cry_q <= '0;
            for (int l = 0; l < STAGES; l++) begin
                a_q[l] <= '0;
                b_q[l] <= '0;
                s_q[l] <= '0;
            end
            out_vld_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            vld_q <= vld_d;
            cry_q <= cry_d;
            for (int l = 0; l < STAGES; l++) begin
                a_q[l] <= a_d[l];
                b_q[l] <= b_d[l];
                s_q[l] <= s_d[l];
            end
            out_vld_q <= out_vld_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_vld_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Four configurations (16/2, 4/1, 32/1, 64/4) share one operand stream; a queue scoreboard per
// instance holds arithmetic expectations, and directed tables cover the 16-bit corner cases.
module tb_cla_pipe_adder;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic [63:0] a_in, b_in;
    logic        cin_in, sub_in;
    logic [3:0]  irdy, ovld, ordy;
    logic [63:0] sum_x [4];
    logic [3:0]  cout_x, ovf_x, zero_x;

    int total = 0;
    int bad   = 0;
    int ws  [4] = '{16, 4, 32, 64};
    int lat [4] = '{2, 1, 8, 4};

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int W = (gi == 0) ? 16 : (gi == 1) ? 4 : (gi == 2) ? 32 : 64;
        localparam int G = (gi == 0) ? 2  : (gi == 1) ? 1 : (gi == 2) ? 1  : 4;
        logic [W-1:0] s_w;
        cla_pipe_adder #(.WIDTH(W), .GPS(G)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[gi]),
            .a(a_in[W-1:0]), .b(b_in[W-1:0]), .cin(cin_in), .sub(sub_in),
            .out_valid(ovld[gi]), .out_ready(ordy[gi]), .sum(s_w),
            .cout(cout_x[gi]), .ovf(ovf_x[gi]), .zero(zero_x[gi])
        );
        assign sum_x[gi] = 64'(s_w);
    end

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    res_t exp_q [4][$];
    res_t mon_e;

    task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic sb, input int w);
        logic [64:0] mask;
        logic [64:0] full;
        logic [63:0] aa, bb, s;
        res_t r;
        mask   = (65'd1 << w) - 65'd1;
        aa     = a & mask[63:0];
        bb     = (sb ? ~b : b) & mask[63:0];
        full   = {1'b0, aa} + {1'b0, bb} + 65'(sb ? 1'b1 : ci);
        s      = full[63:0] & mask[63:0];
        r.sum  = s;
        r.cout = full[w];
        r.ovf  = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        r.zero = (s == 64'd0);
        return r;
    endfunction

    function automatic logic [66:0] got(input int i);
        return {sum_x[i], cout_x[i], ovf_x[i], zero_x[i]};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) exp_q[i].delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ovld[i] && ordy[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk($sformatf("unexpected_out%0d", i), 67'(ovld[i]), 67'd0);
                    end else begin
                        mon_e = exp_q[i].pop_front();
                        chk($sformatf("stream%0d", i), got(i), mon_e);
                    end
                end
                if (in_valid && irdy[i])
                    exp_q[i].push_back(model(a_in, b_in, cin_in, sub_in, ws[i]));
            end
        end
    end

    task automatic drive_rand();
        in_valid = 1'b1;
        a_in     = {$urandom, $urandom};
        b_in     = {$urandom, $urandom};
        case ($urandom_range(3))
            0: b_in = ~a_in;
            1: a_in = '1;
            default: ;
        endcase
        cin_in = 1'($urandom_range(1));
        sub_in = 1'($urandom_range(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t        vt [10];
    logic [31:0] vm [4];
    logic [66:0] hold_v;
    res_t        e1;
    int          cyc;

    initial begin
        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vt[2] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vt[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vt[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
        vt[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vt[8] = '{16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h00FE, 1'b1, 1'b0, 1'b0};
        vt[9] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
        cin_in = 1'b0; sub_in = 1'b0; ordy = 4'hF;

        // Reset held with random activity on the inputs
        repeat (4) begin
            @(posedge clk); #1;
            drive_rand();
            in_valid = 1'($urandom_range(1));
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_vld%0d", i), 67'(ovld[i]), 67'd0);
            chk($sformatf("rst_out%0d", i), got(i), 67'd0);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 67'(irdy), 67'hF);

        // Directed 16-bit vectors with latency check
        for (int v = 0; v < 10; v++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            a_in = 64'(vt[v].a); b_in = 64'(vt[v].b);
            cin_in = vt[v].cin; sub_in = vt[v].sub;
            @(posedge clk); #1;
            in_valid = 1'b0;
            cyc = 0;
            while (!ovld[0] && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk($sformatf("lat_v%0d", v), 67'(cyc), 67'd2);
            chk($sformatf("vec%0d", v), 67'({sum_x[0][15:0], cout_x[0], ovf_x[0], zero_x[0]}),
                67'({vt[v].sum, vt[v].cout, vt[v].ovf, vt[v].zero}));
        end

        // Back-to-back bursts of 8: each instance shows 8 consecutive valids after its latency
        for (int r = 0; r < 3; r++) begin
            repeat (12) @(posedge clk);
            #1;
            drive_rand();
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                for (int i = 0; i < 4; i++) vm[i][k] = ovld[i];
                if (k < 7) drive_rand();
                else in_valid = 1'b0;
            end
            for (int i = 0; i < 4; i++)
                chk($sformatf("burst%0d_valid_pattern%0d", r, i), 67'(vm[i][19:0]),
                    67'((32'hFF << lat[i]) & 32'hFFFFF));
        end

        // Random gaps with random backpressure on the 16-bit instance
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            drive_rand();
            in_valid = ($urandom_range(3) != 0);
            ordy[0]  = ($urandom_range(2) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; ordy[0] = 1'b1;

        // Backpressure: hold out_ready low five cycles with a result waiting
        repeat (12) @(posedge clk);
        #1;
        drive_rand();
        @(posedge clk); #1;
        drive_rand();
        @(posedge clk); #1;
        drive_rand();
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        chk("bp_first_valid", 67'(ovld[0]), 67'd1);
        hold_v = got(0);
        drive_rand();
        for (int h = 0; h < 5; h++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_in_ready%0d", h), 67'(irdy[0]), 67'd0);
            chk($sformatf("bp_valid%0d", h), 67'(ovld[0]), 67'd1);
            chk($sformatf("bp_stable%0d", h), got(0), hold_v);
            drive_rand();
        end
        ordy[0] = 1'b1;
        in_valid = 1'b0;

        // Mid-flight reset pulse with two beats inside the 16-bit pipeline
        repeat (12) @(posedge clk);
        #1;
        drive_rand();
        @(posedge clk); #1;
        drive_rand();
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", 67'(ovld), 67'd0);
        chk("mrst_out", got(0), 67'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("mrst_quiet%0d", k), 67'(ovld), 67'd0);
        end
        drive_rand();
        e1 = model(a_in, b_in, cin_in, sub_in, 16);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!ovld[0] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("mrst_lat", 67'(cyc), 67'd2);
        chk("mrst_first_beat", got(0), e1);

        // Drain all scoreboards
        cyc = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
               && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("drain_left", 67'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()),
            67'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
